// File: rtl/inst_fetch_bridge.sv
// Instruction-fetch responder: multi-cycle base-SRAM reads behind a one-entry
// fetch buffer, with stall request and misaligned/out-of-window fault flags.
module inst_fetch_bridge #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [9:0]  WINDOW_BASE = 10'h200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic        stallreq_o,
    output logic        adel_o,
    output logic        berr_o,
    output logic [19:0] sram_addr_o,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o,
    output logic [3:0]  sram_be_n_o,
    input  logic [31:0] sram_data_i
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 20;

    typedef enum logic [0:0] {IDLE = 1'b0, READ = 1'b1} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        req_pc;
    logic               buf_valid;
    logic [31:0]        buf_pc;
    logic [31:0]        buf_inst;

    logic               aligned;
    logic               inwin;
    logic               hit;
    logic               need;
    logic               start;
    logic               abort;

    assign sram_we_n_o = 1'b1;
    assign sram_be_n_o = 4'b0000;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = READ;
            READ: if (abort || cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address decode, buffer hit and pipeline-facing outputs
    always_comb begin
        aligned    = (pc_i[1:0] == 2'b00);
        inwin      = (pc_i[31:22] == WINDOW_BASE);
        hit        = buf_valid && (buf_pc == pc_i);
        adel_o     = ce_i && !aligned;
        berr_o     = ce_i && aligned && !inwin;
        need       = ce_i && aligned && inwin && !hit;
        stallreq_o = need && !flush_i;
        inst_o     = (ce_i && aligned && inwin && hit) ? buf_inst : 32'h0;
        start      = (state == IDLE) && need && !flush_i;
        abort      = flush_i || !ce_i || (pc_i != req_pc);
    end

    // SRAM control, wait counter and fetch buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            req_pc      <= 32'h0;
            buf_valid   <= 1'b0;
            buf_pc      <= 32'h0;
            buf_inst    <= 32'h0;
            sram_addr_o <= '0;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        req_pc      <= pc_i;
                        sram_addr_o <= ADDR_W'(pc_i[21:2]);
                        sram_ce_n_o <= 1'b0;
                        sram_oe_n_o <= 1'b0;
                        cnt         <= CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        sram_ce_n_o <= 1'b1;
                        sram_oe_n_o <= 1'b1;
                    end
                end
                READ: begin
                    if (abort) begin
                        buf_valid   <= 1'b0;
                        sram_ce_n_o <= 1'b1;
                        sram_oe_n_o <= 1'b1;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        buf_inst    <= sram_data_i;
                        buf_pc      <= req_pc;
                        buf_valid   <= 1'b1;
                        sram_ce_n_o <= 1'b1;
                        sram_oe_n_o <= 1'b1;
                    end
                end
                default: begin
                    sram_ce_n_o <= 1'b1;
                    sram_oe_n_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge: default build (WAIT_CYCLES=2) and a
// WAIT_CYCLES=1 build driven from one linear stimulus sequence.
module tb_inst_fetch_bridge;

    logic        clk = 1'b0;
    logic        rst;

    logic        ce, flush;
    logic [31:0] pc, sdata;
    logic [31:0] inst;
    logic        stall, adel, berr, we_n, ce_n, oe_n;
    logic [19:0] addr;
    logic [3:0]  be_n;

    logic        ce1, flush1;
    logic [31:0] pc1, sdata1;
    logic [31:0] inst1;
    logic        stall1, adel1, berr1, we_n1, ce_n1, oe_n1;
    logic [19:0] addr1;
    logic [3:0]  be_n1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_fetch_bridge #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .ce_i(ce), .pc_i(pc), .flush_i(flush),
        .inst_o(inst), .stallreq_o(stall), .adel_o(adel), .berr_o(berr),
        .sram_addr_o(addr), .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n),
        .sram_we_n_o(we_n), .sram_be_n_o(be_n), .sram_data_i(sdata)
    );

    inst_fetch_bridge #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .ce_i(ce1), .pc_i(pc1), .flush_i(flush1),
        .inst_o(inst1), .stallreq_o(stall1), .adel_o(adel1), .berr_o(berr1),
        .sram_addr_o(addr1), .sram_ce_n_o(ce_n1), .sram_oe_n_o(oe_n1),
        .sram_we_n_o(we_n1), .sram_be_n_o(be_n1), .sram_data_i(sdata1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; pc = 32'h0; flush = 1'b0; sdata = 32'h0;
        ce1 = 1'b0; pc1 = 32'h0; flush1 = 1'b0; sdata1 = 32'h0;
        tick(); tick();
        rst = 1'b0;
        #1;
        // Reset state
        chk("rst_ce_n", 32'(ce_n), 32'h1);
        chk("rst_oe_n", 32'(oe_n), 32'h1);
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_adel", 32'(adel), 32'h0);
        chk("rst_berr", 32'(berr), 32'h0);
        chk("tie_we_n", 32'(we_n), 32'h1);
        chk("tie_be_n", 32'(be_n), 32'h0);

        // Cold fetch at 0x80000000
        ce = 1'b1; pc = 32'h8000_0000; sdata = 32'h3C01_1234;
        #1;
        chk("cold_t0_stall", 32'(stall), 32'h1);
        chk("cold_t0_ce_n", 32'(ce_n), 32'h1);
        tick();
        chk("cold_t1_stall", 32'(stall), 32'h1);
        chk("cold_t1_ce_n", 32'(ce_n), 32'h0);
        chk("cold_t1_oe_n", 32'(oe_n), 32'h0);
        chk("cold_t1_addr", 32'(addr), 32'h0);
        tick();
        chk("cold_t2_stall", 32'(stall), 32'h1);
        chk("cold_t2_ce_n", 32'(ce_n), 32'h0);
        tick();
        chk("cold_t3_stall", 32'(stall), 32'h0);
        chk("cold_t3_inst", inst, 32'h3C01_1234);
        chk("cold_t3_ce_n", 32'(ce_n), 32'h1);

        // Sequential fetch at 0x80000004
        tick();
        pc = 32'h8000_0004; sdata = 32'h2421_0001;
        #1;
        chk("seq_t0_stall", 32'(stall), 32'h1);
        chk("seq_t0_inst", inst, 32'h0);
        tick();
        chk("seq_t1_addr", 32'(addr), 32'h1);
        chk("seq_t1_ce_n", 32'(ce_n), 32'h0);
        chk("seq_t1_stall", 32'(stall), 32'h1);
        tick();
        chk("seq_t2_stall", 32'(stall), 32'h1);
        tick();
        chk("seq_t3_stall", 32'(stall), 32'h0);
        chk("seq_t3_inst", inst, 32'h2421_0001);
        sdata = 32'hDEAD_DEAD;
        tick();
        chk("rep_stall", 32'(stall), 32'h0);
        chk("rep_inst", inst, 32'h2421_0001);
        chk("rep_ce_n", 32'(ce_n), 32'h1);
        tick();
        chk("rep2_ce_n", 32'(ce_n), 32'h1);
        chk("rep2_inst", inst, 32'h2421_0001);

        // Flush on the first READ cycle
        pc = 32'h8000_0010; sdata = 32'h1111_1111;
        #1;
        chk("fl_t0_stall", 32'(stall), 32'h1);
        tick();
        chk("fl_t1_ce_n", 32'(ce_n), 32'h0);
        chk("fl_t1_addr", 32'(addr), 32'h4);
        flush = 1'b1; pc = 32'h8000_1000; sdata = 32'hAAAA_5555;
        #1;
        chk("fl_t1_stall", 32'(stall), 32'h0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_t2_ce_n", 32'(ce_n), 32'h1);
        chk("fl_t2_oe_n", 32'(oe_n), 32'h1);
        chk("fl_t2_bufv", 32'(dut.buf_valid), 32'h0);
        chk("fl_t2_stall", 32'(stall), 32'h1);
        tick();
        chk("fl_t3_addr", 32'(addr), 32'h400);
        chk("fl_t3_ce_n", 32'(ce_n), 32'h0);
        tick();
        chk("fl_t4_stall", 32'(stall), 32'h1);
        tick();
        chk("fl_t5_stall", 32'(stall), 32'h0);
        chk("fl_t5_inst", inst, 32'hAAAA_5555);

        // Misaligned fetch
        tick();
        pc = 32'h8000_0002;
        #1;
        chk("mis_adel", 32'(adel), 32'h1);
        chk("mis_berr", 32'(berr), 32'h0);
        chk("mis_stall", 32'(stall), 32'h0);
        chk("mis_inst", inst, 32'h0);
        tick();
        chk("mis_ce_n", 32'(ce_n), 32'h1);

        // Out-of-window fetch
        pc = 32'hBFC0_0000;
        #1;
        chk("oow_berr", 32'(berr), 32'h1);
        chk("oow_adel", 32'(adel), 32'h0);
        chk("oow_stall", 32'(stall), 32'h0);
        chk("oow_inst", inst, 32'h0);
        tick();
        chk("oow_ce_n", 32'(ce_n), 32'h1);
        ce = 1'b0;
        #1;
        chk("oow_noce_berr", 32'(berr), 32'h0);
        chk("oow_noce_adel", 32'(adel), 32'h0);
        pc = 32'h8000_0003;
        #1;
        chk("mis_noce_adel", 32'(adel), 32'h0);
        chk("mis_noce_stall", 32'(stall), 32'h0);

        // WAIT_CYCLES=1 build: two-cycle stall per miss
        tick();
        ce1 = 1'b1; pc1 = 32'h8000_0020; sdata1 = 32'h0000_BEEF;
        #1;
        chk("w1_t0_stall", 32'(stall1), 32'h1);
        tick();
        chk("w1_t1_stall", 32'(stall1), 32'h1);
        chk("w1_t1_ce_n", 32'(ce_n1), 32'h0);
        chk("w1_t1_addr", 32'(addr1), 32'h8);
        tick();
        chk("w1_t2_stall", 32'(stall1), 32'h0);
        chk("w1_t2_inst", inst1, 32'h0000_BEEF);
        chk("w1_t2_ce_n", 32'(ce_n1), 32'h1);

        // Drop ce_i during READ: abort, no buffer update
        tick();
        pc1 = 32'h8000_0024; sdata1 = 32'h0000_CAFE;
        #1;
        chk("w1_ab_t0_stall", 32'(stall1), 32'h1);
        tick();
        chk("w1_ab_t1_ce_n", 32'(ce_n1), 32'h0);
        ce1 = 1'b0;
        #1;
        chk("w1_ab_t1_stall", 32'(stall1), 32'h0);
        chk("w1_ab_t1_inst", inst1, 32'h0);
        tick();
        chk("w1_ab_t2_ce_n", 32'(ce_n1), 32'h1);
        chk("w1_ab_t2_bufv", 32'(dut1.buf_valid), 32'h0);
        ce1 = 1'b1;
        #1;
        chk("w1_ab_t2_stall", 32'(stall1), 32'h1);
        chk("w1_ab_t2_inst", inst1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch_bridge.md
Name: inst_fetch_bridge

Overview:
Responder side of the instruction-fetch interface. It accepts pc/ce from the PC stage, performs multi-cycle reads from the external base SRAM, and returns the instruction to IF/ID. While the word is not yet available, it raises a stall request to the pipeline control module. A one-entry fetch buffer holds the last fetched word. The block also detects misaligned and out-of-window fetch addresses.

Parameters:
WAIT_CYCLES, 2, SRAM read latency in clock cycles; legal range 1..15.
WINDOW_BASE, 10'h200, required value of pc[31:22]; the base RAM maps to 0x80000000-0x803FFFFF.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
ce_i  input  1  fetch enable from PC stage; 1 = fetch requested
pc_i  input  32  fetch address from PC stage
flush_i  input  1  exception flush; aborts any in-flight read
inst_o  output  32  instruction to IF/ID; 0 when not a hit
stallreq_o  output  1  stall request to control module (feeds stall[0]/stall[1])
adel_o  output  1  misaligned fetch address (pc_i[1:0] != 0)
berr_o  output  1  fetch address outside the RAM window
sram_addr_o  output  20  SRAM word address
sram_ce_n_o  output  1  SRAM chip enable, active-low
sram_oe_n_o  output  1  SRAM output enable, active-low
sram_we_n_o  output  1  SRAM write enable, tied to 1
sram_be_n_o  output  4  SRAM byte enables, tied to 4'b0000
sram_data_i  input  32  SRAM read data

Behaviour:
- Reset (rst=1 at posedge clk):
  - state=IDLE, buf_valid=0, buf_pc=0, buf_inst=0.
  - sram_ce_n_o=1, sram_oe_n_o=1, sram_addr_o=0.
  - All combinational outputs then evaluate to 0 while ce_i=0.
  - Reset mid-READ abandons the read; no buffer update.
- Combinational decode:
  - aligned = (pc_i[1:0]==0).
  - inwin = (pc_i[31:22]==WINDOW_BASE).
  - hit = buf_valid & (buf_pc==pc_i).
  - adel_o = ce_i & ~aligned.
  - berr_o = ce_i & aligned & ~inwin.
  - need = ce_i & aligned & inwin & ~hit.
  - stallreq_o = need & ~flush_i.
  - inst_o = (ce_i & aligned & inwin & hit) ? buf_inst : 32'h0.
- FSM states: IDLE, READ. Registers: cnt (4-bit), req_pc (32-bit).
- IDLE:
  - If need & ~flush_i: req_pc<=pc_i, sram_addr_o<=pc_i[21:2], sram_ce_n_o<=0, sram_oe_n_o<=0, cnt<=WAIT_CYCLES-1, go to READ.
  - Otherwise remain in IDLE with SRAM deasserted.
- READ:
  - SRAM controls stay asserted and sram_addr_o stays stable.
  - If flush_i=1, or ce_i=0, or pc_i!=req_pc: abort. Deassert SRAM next cycle, buf_valid<=0, go to IDLE. A new request may start from IDLE on the following cycle.
  - Else if cnt!=0: cnt<=cnt-1.
  - Else (cnt==0): buf_inst<=sram_data_i, buf_pc<=req_pc, buf_valid<=1, deassert SRAM, go to IDLE.
- Latency:
  - A miss accepted at cycle T makes READ occupy cycles T+1..T+WAIT_CYCLES.
  - Data is captured at the end of cycle T+WAIT_CYCLES.
  - The hit is visible, with stallreq_o=0, in cycle T+WAIT_CYCLES+1.
  - stallreq_o is therefore high for WAIT_CYCLES+1 consecutive cycles per miss.
- Repeated pc (pipeline stalled by another stage): the buffer hit returns the instruction with zero stall and no SRAM access.
- flush_i in IDLE: no access starts that cycle; buffer contents are kept.
- adel_o or berr_o asserted: no SRAM access, no stall, inst_o=0. The fault is reported purely combinationally in the same cycle.
- The buffer is never invalidated except by an abort or by reset. Self-modifying code is not supported.

Test Plan:
- Reset then cold fetch: rst high 2 cycles, then ce_i=1, pc_i=0x80000000, sram_data_i=0x3C011234. Required: stallreq_o=1 for 3 cycles; sram_addr_o=0 with ce_n/oe_n=0 for 2 cycles; cycle 4 inst_o=0x3C011234 and stallreq_o=0.
- Sequential fetch: after the above, pc_i=0x80000004, data 0x24210001. Required: sram_addr_o=1, 3-cycle stall, then inst_o=0x24210001. Returning to pc_i=0x80000004 next cycle is a hit with no stall and no SRAM activity.
- Flush mid-read: start fetch at 0x80000010 and assert flush_i on the first READ cycle with pc_i=0x80001000. Required: SRAM deasserted next cycle, buf_valid=0, fetch of 0x80001000 (sram_addr_o=0x400) begins the cycle after, and its data is returned correctly.
- Misaligned: ce_i=1, pc_i=0x80000002. Required: adel_o=1, berr_o=0, stallreq_o=0, inst_o=0, sram_ce_n_o stays 1.
- Out of window: pc_i=0xBFC00000. Required: berr_o=1, adel_o=0, no stall, no SRAM access. With ce_i=0 both flags are 0.
- WAIT_CYCLES=1 build: a miss at 0x80000020 stalls exactly 2 cycles. Dropping ce_i during READ aborts the read with no buffer update.
